// File: rtl/mm_exp_pkg.sv
// Shared constants and state encoding for the mm_exp controller and the
// Montgomery multiplier it drives. Field prime q = 2^255 - 19.
package mm_exp_pkg;

  localparam int unsigned FieldW = 255;
  localparam int unsigned IdxW   = 8;

  localparam logic [FieldW-1:0] Q        = ~255'd18;
  // 2^255 mod q, i.e. the Montgomery representation of 1.
  localparam logic [FieldW-1:0] ONE_MONT = 255'd19;

  typedef enum logic [1:0] {
    StIdle,
    StSqr,
    StMul,
    StDone
  } mm_exp_state_e;

endpackage

// File: rtl/mm_exp_msb_find.sv
// Priority encoder returning the index of the highest set bit of i_vec.
// Used by mm_exp only when MM_EXP_SKIP_LZ_EN is defined.
module mm_exp_msb_find
  import mm_exp_pkg::*;
#(
  parameter int unsigned W = 255
) (
  input  logic [W-1:0]    i_vec,
  output logic [IdxW-1:0] o_idx,
  output logic            o_zero
);

  always_comb begin
    o_idx  = '0;
    o_zero = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_idx  = IdxW'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mm_exp.sv
// Left-to-right square-and-multiply controller for an external combinational
// Montgomery multiplier. Optional macro: MM_EXP_SKIP_LZ_EN (skip leading zeros).
module mm_exp
  import mm_exp_pkg::*;
#(
  parameter int unsigned W = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_exp,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_result,
  output logic [W-1:0] o_mm_x,
  output logic [W-1:0] o_mm_y,
  input  logic [W-1:0] i_mm_r
);

  mm_exp_state_e r_state, w_state_d;
  logic [W-1:0]    r_acc, w_acc_d;
  logic [W-1:0]    r_base, w_base_d;
  logic [W-1:0]    r_exp, w_exp_d;
  logic [IdxW-1:0] r_idx, w_idx_d;

`ifdef MM_EXP_SKIP_LZ_EN
  logic [IdxW-1:0] w_msb;
  logic            w_exp_zero;

  mm_exp_msb_find #(
    .W (W)
  ) u_msb_find (
    .i_vec  (i_exp),
    .o_idx  (w_msb),
    .o_zero (w_exp_zero)
  );
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_base  <= '0;
      r_exp   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_base  <= w_base_d;
      r_exp   <= w_exp_d;
      r_idx   <= w_idx_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_base_d  = r_base;
    w_exp_d   = r_exp;
    w_idx_d   = r_idx;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_base_d = i_base;
          w_exp_d  = i_exp;
          w_acc_d  = ONE_MONT;
`ifdef MM_EXP_SKIP_LZ_EN
          if (w_exp_zero) begin
            w_state_d = StDone;
          end else begin
            w_idx_d   = w_msb;
            w_state_d = StSqr;
          end
`else
          w_idx_d   = IdxW'(W - 1);
          w_state_d = StSqr;
`endif
        end
      end
      StSqr: begin
        w_acc_d = i_mm_r;
        if (r_exp[r_idx]) begin
          w_state_d = StMul;
        end else if (r_idx == '0) begin
          w_state_d = StDone;
        end else begin
          w_idx_d = r_idx - IdxW'(1);
        end
      end
      StMul: begin
        w_acc_d = i_mm_r;
        if (r_idx == '0) begin
          w_state_d = StDone;
        end else begin
          w_idx_d   = r_idx - IdxW'(1);
          w_state_d = StSqr;
        end
      end
      StDone: begin
        if (i_out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_result    = '0;
    o_mm_x      = '0;
    o_mm_y      = '0;
    unique case (r_state)
      StIdle: o_in_ready = 1'b1;
      StSqr: begin
        o_mm_x = r_acc;
        o_mm_y = r_acc;
      end
      StMul: begin
        o_mm_x = r_acc;
        o_mm_y = r_base;
      end
      StDone: begin
        o_out_valid = 1'b1;
        o_result    = r_acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mm_exp.sv
// Directed bench for mm_exp; a bit-serial Montgomery multiplier model stands in
// for the external multiplier. Define MM_EXP_SKIP_LZ_EN to match a skip build.
module tb_mm_exp;
  import mm_exp_pkg::*;

  localparam int unsigned W = 255;
  localparam int unsigned Bound = 2000;

`ifdef MM_EXP_SKIP_LZ_EN
  localparam int unsigned LatE1  = 2;    // msb 0 + 1, one multiply
  localparam int unsigned LatE3  = 4;    // msb 1 + 1, two multiplies
  localparam int unsigned LatE0  = 0;
  localparam int unsigned LatE2  = 3;    // msb 1 + 1, one multiply
`else
  localparam int unsigned LatE1  = 256;
  localparam int unsigned LatE3  = 257;
  localparam int unsigned LatE0  = 255;
  localparam int unsigned LatE2  = 256;
`endif
  // q-2 = 2^255-21 has bit 254 set and 253 ones: 255 squarings + 253 multiplies.
  localparam int unsigned LatQm2 = 508;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] base = '0;
  logic [W-1:0] expo = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] mm_x, mm_y, mm_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_exp #(
    .W (W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_base      (base),
    .i_exp       (expo),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_mm_x      (mm_x),
    .o_mm_y      (mm_y),
    .i_mm_r      (mm_r)
  );

  // MM(x,y) = x*y*2^-255 mod q, radix-2 Montgomery reduction.
  function automatic logic [W-1:0] mm(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] a;
    a = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (x[i]) a = a + {2'b00, y};
      if (a[0]) a = a + {2'b00, Q};
      a = a >> 1;
    end
    if (a >= {2'b00, Q}) a = a - {2'b00, Q};
    return a[W-1:0];
  endfunction

  always_comb mm_r = mm(mm_x, mm_y);

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one request, check latency/result, optionally stall, then hand-shake.
  task automatic run_req(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                         input int unsigned lat, input logic [W-1:0] res,
                         input int unsigned stall);
    int unsigned cnt;
    check({tag, "_ready"}, W'(in_ready), W'(1));
    base     = b;
    expo     = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    base     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    expo     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cnt = 0;
    while (!out_valid && cnt < Bound) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_latency"}, W'(cnt), W'(lat));
    check({tag, "_result"}, result, res);
    check({tag, "_busy"}, W'(in_ready), W'(0));
    for (int i = 0; i < int'(stall); i++) begin
      @(posedge clk);
      #1;
      check({tag, "_stall_result"}, result, res);
      check({tag, "_stall_valid"}, W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, W'(out_valid), W'(0));
  endtask

  logic [W-1:0] b_val;
  logic [W-1:0] r_b2;
  logic [W-1:0] r_b3;
  logic [W-1:0] q_m2;
  int unsigned  spurious;

  initial begin
    b_val = 255'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2;
    r_b2  = mm(b_val, b_val);
    r_b3  = mm(r_b2, b_val);
    q_m2  = Q - 255'd2;

    #12;
    check("rst_ready", W'(in_ready), W'(1));
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_mm_x", mm_x, '0);
    check("rst_mm_y", mm_y, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_req("exp1", b_val, 255'd1, LatE1, b_val, 0);

    // First operation after accept must be the square of ONE_MONT.
    base     = b_val;
    expo     = 255'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("first_sq_x", mm_x, ONE_MONT);
    check("first_sq_y", mm_y, ONE_MONT);
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", W'(in_ready), W'(1));
    check("abort_mm_x", mm_x, '0);
    check("abort_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious++;
    end
    check("abort_no_result", W'(spurious), W'(0));

    run_req("exp3", b_val, 255'd3, LatE3, r_b3, 0);
    run_req("exp0", b_val, 255'd0, LatE0, ONE_MONT, 0);
    run_req("inv_one", ONE_MONT, q_m2, LatQm2, ONE_MONT, 10);
    run_req("exp2", b_val, 255'd2, LatE2, r_b2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_exp.md
# mm_exp

Sequential modular-exponentiation controller that feeds the combinational 255-bit Montgomery multiplier. It accepts a Montgomery-domain base and a 255-bit exponent, then drives the multiplier's x/y operands one product per cycle using left-to-right square-and-multiply. It returns base^exp in Montgomery form. It sits directly upstream of the multiplier, which it accesses through dedicated operand/result ports. Typical use is modular inversion via exp = q−2.

## Interface
Parameters:
- `W`, 255, operand/exponent width; fixed by the field.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_in_valid`  in  1  request valid.
- `o_in_ready`  out  1  high only in IDLE.
- `i_base`  in  255  base in Montgomery form; must be < q.
- `i_exp`  in  255  exponent, unsigned.
- `o_out_valid`  out  1  result valid; held until accepted.
- `i_out_ready`  in  1  consumer accepts result.
- `o_result`  out  255  base^exp, Montgomery form, in [0, q).
- `o_mm_x`, `o_mm_y`  out  255  multiplier operands.
- `i_mm_r`  in  255  multiplier result, MM(x,y) = x·y·2^-255 mod q, combinational in the same cycle.

## Operation
- Registers: `acc`, `base_r`, `exp_r`, 8-bit bit index `idx`, and state.
- States are IDLE, SQR, MUL and DONE.
- **IDLE:** the request is accepted when `i_in_valid & o_in_ready` is true at an edge.
  - On accept: latch `i_base` and `i_exp`, set `acc` = ONE_MONT, set `idx` = 254, and go to SQR.
  - Inputs are ignored after the accept edge.
- **SQR:** drive x = y = `acc`; then `acc` ← `i_mm_r`.
  - If `exp_r[idx]` is 1, go to MUL.
  - Else if `idx` == 0, go to DONE.
  - Else decrement `idx` and stay in SQR.
- **MUL:** drive x = `acc`, y = `base_r`; then `acc` ← `i_mm_r`.
  - If `idx` == 0, go to DONE.
  - Else decrement `idx` and go to SQR.
- **DONE:** `o_out_valid` = 1 and `o_result` = `acc`.
  - On `i_out_ready`, go to IDLE; `o_out_valid` drops the next cycle.
- `o_mm_x` and `o_mm_y` are 0 in IDLE and DONE.
- Arithmetic:
  - The controller does no arithmetic itself; all reduction happens in the multiplier.
  - `acc` stays in [0, q) provided `i_mm_r` does.
- exp = 0 yields ONE_MONT; exp = 1 yields `i_base`.

## Timing
- Reset values:
  - state = IDLE, so `o_in_ready` = 1 after reset release.
  - `acc`, `base_r`, `exp_r`, `idx`, `o_result`, `o_mm_x`, `o_mm_y` = 0.
  - `o_out_valid` = 0.
- Latency with accept at edge k:
  - Each multiplier operation takes one cycle.
  - N = 255 + popcount(exp) operations, in cycles k+1 … k+N.
  - `o_out_valid` rises in cycle k+N+1.
- Back-to-back requests: the earliest next accept is the edge after the result handshake, because `o_in_ready` rises only once the state is back in IDLE.
- Backpressure: while `i_out_ready` = 0 in DONE, `o_result` and `o_out_valid` are stable and `o_in_ready` = 0.
- Reset mid-operation: state returns to IDLE immediately (asynchronously). No `o_out_valid` pulse occurs for the aborted request.

## Configuration
- `MM_EXP_SKIP_LZ_EN` defined (leading-zero skip):
  - On accept, `idx` is loaded with the position of the MSB of `i_exp`, so leading-zero squarings of ONE_MONT are skipped.
  - If `i_exp` == 0, go directly to DONE with `acc` = ONE_MONT; `o_out_valid` then rises at k+1.
  - N = (msb+1) + popcount(exp).
- `MM_EXP_SKIP_LZ_EN` undefined: latency is data-independent in the bit length, always 255 squarings.

## Structure
- Shared package holds:
  - constants Q and ONE_MONT (= 2^255 mod q = 2^255 − q), shared with the multiplier;
  - the state enum.
- Sub-module:
  - The multiplier stays external and is instantiated by the parent, alongside mm_exp.
  - One natural sub-module is `msb_find` (255-bit priority encoder), used only under `MM_EXP_SKIP_LZ_EN`.

## Test plan
- Reset release → `o_in_ready` = 1, `o_out_valid` = 0, `o_mm_x` = `o_mm_y` = 0; assert `i_rst` mid-SQR → IDLE next cycle with no result.
- base = B, exp = 1 (no skip) → `o_result` = B; `o_out_valid` at k+257 (256 ops).
- exp = 3, no skip → `o_result` = MM(MM(B,B),B), at k+258.
- exp = 3, `MM_EXP_SKIP_LZ_EN` → same value, at k+5.
- exp = 0 → `o_result` = ONE_MONT: at k+256 without skip, k+1 with skip.
- base = ONE_MONT, exp = q−2, with `i_out_ready` held low 10 cycles → `o_result` = ONE_MONT, stable throughout the stall. Then a back-to-back request with exp = 2 → MM(B,B), checked against a reference model.
